// File: rtl/free_list_pkg.sv
// free_list_pkg: register-file sizing and the release/allocate record shared by rename and retire.
package free_list_pkg;
  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PREG_W = $clog2(NUM_PREGS);
  typedef struct packed {
    logic valid;
    logic [PREG_W-1:0] reg_addr;
  } freeRegStruct;
endpackage

// File: rtl/free_list_if.sv
// free_list_if: release, allocate and status signals between the free list and rename/retire.
interface free_list_if #(
  parameter int CAP = free_list_pkg::NUM_PREGS - free_list_pkg::NUM_AREGS
);
  import free_list_pkg::*;
  localparam int CW = $clog2(CAP + 1);
  freeRegStruct freeReg_a, freeReg_b, alloc_a, alloc_b;
  logic alloc_ack_a, alloc_ack_b;
  logic [CW-1:0] free_count;
  logic overflow_err, underflow_err;
  modport master (
    output freeReg_a, freeReg_b, alloc_ack_a, alloc_ack_b,
    input alloc_a, alloc_b, free_count, overflow_err, underflow_err
  );
  modport slave (
    input freeReg_a, freeReg_b, alloc_ack_a, alloc_ack_b,
    output alloc_a, alloc_b, free_count, overflow_err, underflow_err
  );
endinterface

// File: rtl/free_list.sv
// free_list: dual-ported circular FIFO of free physical registers, two pushes and two pops per cycle.
module free_list #(
  parameter int NUM_PREGS = free_list_pkg::NUM_PREGS,
  parameter int NUM_AREGS = free_list_pkg::NUM_AREGS,
  parameter int CAP = NUM_PREGS - NUM_AREGS
) (
  input logic clk,
  input logic rst_n,
  free_list_if.slave bus
);
  import free_list_pkg::*;
  localparam int CW = $clog2(CAP + 1);
  localparam int PW = CAP > 1 ? $clog2(CAP) : 1;
  logic [PREG_W-1:0] mem [CAP];
  logic [PW-1:0] head, tail, head_1, tail_1, wr_b;
  logic [CW-1:0] count;
  logic va, vb, bad, push_a, push_b, acc_a, acc_b, ovf, unf;
  logic [1:0] pops;
  int room;
  function automatic logic [PW-1:0] wrap(input int p);
    return PW'(p >= CAP ? p - CAP : p);
  endfunction
  always_comb begin
    va = count != '0;
    vb = count > CW'(1);
    head_1 = wrap(int'(head) + 1);
    tail_1 = wrap(int'(tail) + 1);
    bus.alloc_a = '{valid: va, reg_addr: mem[head]};
    bus.alloc_b = '{valid: vb, reg_addr: vb ? mem[head_1] : '0};
    bad = (bus.alloc_ack_b & ~bus.alloc_ack_a) | (bus.alloc_ack_a & ~va) | (bus.alloc_ack_b & ~vb);
    pops = bad ? 2'd0 : {bus.alloc_ack_a & bus.alloc_ack_b, bus.alloc_ack_a & ~bus.alloc_ack_b};
    push_a = bus.freeReg_a.valid && bus.freeReg_a.reg_addr != '0;
    push_b = bus.freeReg_b.valid && bus.freeReg_b.reg_addr != '0;
    room = CAP - int'(count) + int'(pops);
    // b is sacrificed before a when space runs short
    acc_a = push_a && room >= 1;
    acc_b = push_b && room >= 1 + int'(push_a);
    wr_b = acc_a ? tail_1 : tail;
  end
  assign bus.free_count = count;
  assign bus.overflow_err = ovf;
  assign bus.underflow_err = unf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= CW'(CAP);
      ovf <= 1'b0;
      unf <= 1'b0;
      for (int i = 0; i < CAP; i++) mem[i] <= PREG_W'((NUM_AREGS + i) % NUM_PREGS);
    end else begin
      head <= pops == 2'd2 ? wrap(int'(head) + 2) : pops == 2'd1 ? head_1 : head;
      tail <= acc_a && acc_b ? wrap(int'(tail) + 2) : acc_a || acc_b ? tail_1 : tail;
      count <= CW'(int'(count) - int'(pops) + int'(acc_a) + int'(acc_b));
      if (acc_a) mem[tail] <= bus.freeReg_a.reg_addr;
      if (acc_b) mem[wr_b] <= bus.freeReg_b.reg_addr;
      if (bad) unf <= 1'b1;
      if ((push_a && !acc_a) || (push_b && !acc_b)) ovf <= 1'b1;
    end
  end
  a_count_cap: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(CAP));
  a_no_ack_in_reset: assert property (@(posedge clk) !rst_n |-> !(bus.alloc_ack_a || bus.alloc_ack_b));
  a_no_dup_push: assert property (@(posedge clk) disable iff (!rst_n)
    push_a && push_b |-> bus.freeReg_a.reg_addr != bus.freeReg_b.reg_addr);
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: vector table, directed corner sequences and a queue-model random run for free_list.
module tb_free_list;
  import free_list_pkg::*;
  localparam int CAP = NUM_PREGS - NUM_AREGS;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int errors = 0, checks = 0;
  int q[$];
  bit m_ovf, m_unf;
  free_list_if #(.CAP(CAP)) bus();
  free_list #(.NUM_PREGS(NUM_PREGS), .NUM_AREGS(NUM_AREGS), .CAP(CAP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;

  typedef struct {
    bit aa, ab, pav; int par; bit pbv; int pbr;
    bit eva; int ea; bit evb; int eb; int ec; bit eovf, eunf;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit aa, input bit ab, input bit pav, input int par, input bit pbv, input int pbr);
    bus.alloc_ack_a = aa;
    bus.alloc_ack_b = ab;
    bus.freeReg_a = '{valid: pav, reg_addr: PREG_W'(par)};
    bus.freeReg_b = '{valid: pbv, reg_addr: PREG_W'(pbr)};
  endtask

  task automatic model_step(input bit aa, input bit ab, input bit pav, input int par, input bit pbv, input int pbr);
    int n = q.size();
    bit bad, ka, kb;
    int pops, room;
    bad = (ab && !aa) || (aa && n < 1) || (ab && n < 2);
    if (bad) m_unf = 1;
    pops = bad ? 0 : aa ? (ab ? 2 : 1) : 0;
    repeat (pops) void'(q.pop_front());
    room = CAP - q.size();
    ka = pav && par != 0;
    kb = pbv && pbr != 0;
    if (kb && int'(ka) + 1 > room) begin kb = 0; m_ovf = 1; end
    if (ka && room < 1) begin ka = 0; m_ovf = 1; end
    if (ka) q.push_back(par);
    if (kb) q.push_back(pbr);
  endtask

  task automatic step(input bit aa, input bit ab, input bit pav, input int par, input bit pbv, input int pbr);
    drive(aa, ab, pav, par, pbv, pbr);
    model_step(aa, ab, pav, par, pbv, pbr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    int n = q.size();
    chk({tag, ".a_valid"}, int'(bus.alloc_a.valid), int'(n >= 1));
    if (n >= 1) chk({tag, ".a_addr"}, int'(bus.alloc_a.reg_addr), q[0]);
    chk({tag, ".b_valid"}, int'(bus.alloc_b.valid), int'(n >= 2));
    chk({tag, ".b_addr"}, int'(bus.alloc_b.reg_addr), n >= 2 ? q[1] : 0);
    chk({tag, ".count"}, int'(bus.free_count), n);
    chk({tag, ".ovf"}, int'(bus.overflow_err), int'(m_ovf));
    chk({tag, ".unf"}, int'(bus.underflow_err), int'(m_unf));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".a_valid"}, int'(bus.alloc_a.valid), 1);
    chk({tag, ".a_addr"}, int'(bus.alloc_a.reg_addr), 32);
    chk({tag, ".b_valid"}, int'(bus.alloc_b.valid), 1);
    chk({tag, ".b_addr"}, int'(bus.alloc_b.reg_addr), 33);
    chk({tag, ".count"}, int'(bus.free_count), 32);
    chk({tag, ".ovf"}, int'(bus.overflow_err), 0);
    chk({tag, ".unf"}, int'(bus.underflow_err), 0);
  endtask

  task automatic do_reset(input string tag);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1 check_reset(tag);
    q.delete();
    for (int i = 0; i < CAP; i++) q.push_back(NUM_AREGS + i);
    m_ovf = 0;
    m_unf = 0;
    @(negedge clk);
    check_reset({tag, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1, 0, 0, 0, 0, 0, 1, 33, 1, 34, 31, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 1, 33, 1, 34, 31, 0, 0};
    tbl[2] = '{1, 1, 0, 0, 0, 0, 1, 35, 1, 36, 29, 0, 0};
    tbl[3] = '{0, 0, 1, 5, 0, 0, 1, 35, 1, 36, 30, 0, 0};
    tbl[4] = '{0, 0, 1, 0, 1, 7, 1, 35, 1, 36, 31, 0, 0};
    tbl[5] = '{1, 0, 1, 10, 0, 0, 1, 36, 1, 37, 31, 0, 0};
    tbl[6] = '{0, 1, 0, 0, 0, 0, 1, 36, 1, 37, 31, 0, 1};
    #1 do_reset("reset");
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].aa, tbl[i].ab, tbl[i].pav, tbl[i].par, tbl[i].pbv, tbl[i].pbr);
      chk($sformatf("vec%0d.a_valid", i), int'(bus.alloc_a.valid), int'(tbl[i].eva));
      chk($sformatf("vec%0d.a_addr", i), int'(bus.alloc_a.reg_addr), tbl[i].ea);
      chk($sformatf("vec%0d.b_valid", i), int'(bus.alloc_b.valid), int'(tbl[i].evb));
      chk($sformatf("vec%0d.b_addr", i), int'(bus.alloc_b.reg_addr), tbl[i].eb);
      chk($sformatf("vec%0d.count", i), int'(bus.free_count), tbl[i].ec);
      chk($sformatf("vec%0d.ovf", i), int'(bus.overflow_err), int'(tbl[i].eovf));
      chk($sformatf("vec%0d.unf", i), int'(bus.underflow_err), int'(tbl[i].eunf));
    end
    // drain all 32 in pairs, then refill from empty
    do_reset("reset_drain");
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d.a", k), int'(bus.alloc_a.reg_addr), 32 + 2 * k);
      chk($sformatf("drain%0d.b", k), int'(bus.alloc_b.reg_addr), 33 + 2 * k);
      step(1, 1, 0, 0, 0, 0);
    end
    chk("empty.a_valid", int'(bus.alloc_a.valid), 0);
    chk("empty.b_valid", int'(bus.alloc_b.valid), 0);
    chk("empty.b_addr", int'(bus.alloc_b.reg_addr), 0);
    chk("empty.count", int'(bus.free_count), 0);
    chk("empty.ovf", int'(bus.overflow_err), 0);
    chk("empty.unf", int'(bus.underflow_err), 0);
    drive(0, 0, 1, 5, 1, 9);
    #1 chk("no_bypass.a_valid", int'(bus.alloc_a.valid), 0);
    step(0, 0, 1, 5, 1, 9);
    chk("refill.a", int'(bus.alloc_a.reg_addr), 5);
    chk("refill.b", int'(bus.alloc_b.reg_addr), 9);
    chk("refill.b_valid", int'(bus.alloc_b.valid), 1);
    chk("refill.count", int'(bus.free_count), 2);
    step(1, 0, 0, 0, 0, 0);
    chk("one.count", int'(bus.free_count), 1);
    chk("one.a", int'(bus.alloc_a.reg_addr), 9);
    chk("one.b_valid", int'(bus.alloc_b.valid), 0);
    step(1, 1, 0, 0, 0, 0);
    chk("under.unf", int'(bus.underflow_err), 1);
    chk("under.count", int'(bus.free_count), 1);
    chk("under.a", int'(bus.alloc_a.reg_addr), 9);
    step(0, 0, 1, 0, 0, 0);
    chk("zero_rel.count", int'(bus.free_count), 1);
    chk("zero_rel.ovf", int'(bus.overflow_err), 0);
    // full list: one pop makes room for a only
    do_reset("reset_full");
    step(1, 0, 1, 40, 1, 41);
    chk("full.ovf", int'(bus.overflow_err), 1);
    chk("full.count", int'(bus.free_count), 32);
    chk("full.a", int'(bus.alloc_a.reg_addr), 33);
    chk("full.unf", int'(bus.underflow_err), 0);
    repeat (31) step(1, 0, 0, 0, 0, 0);
    chk("full.tail_a", int'(bus.alloc_a.reg_addr), 40);
    chk("full.tail_count", int'(bus.free_count), 1);
    // random traffic against the queue model, legal acks only
    do_reset("reset_rand");
    for (int c = 0; c < 600; c++) begin
      bit aa, ab, pav, pbv;
      int par, pbr;
      aa = q.size() >= 1 && $urandom_range(0, 3) != 0;
      ab = aa && q.size() >= 2 && $urandom_range(0, 1) != 0;
      pav = $urandom_range(0, 2) == 0;
      pbv = $urandom_range(0, 2) == 0;
      par = int'($urandom_range(0, NUM_PREGS - 1));
      pbr = int'($urandom_range(0, NUM_PREGS - 1));
      if (pbr == par) pbr = par ^ 1;
      step(aa, ab, pav, par, pbv, pbr);
      check_model($sformatf("rand%0d", c));
    end
    #2 do_reset("async_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter NUM_PREGS, default 64: physical register count.
REQ-002 Parameter NUM_AREGS, default 32: architectural register count. Physical registers 0..NUM_AREGS-1 are mapped at reset.
REQ-003 Parameter CAP, default NUM_PREGS-NUM_AREGS: free list capacity, 32 by default.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 freeReg_a  input  freeRegStruct  older retiring release (valid, reg_addr) from the retire stage.
REQ-007 freeReg_b  input  freeRegStruct  younger retiring release; same encoding as freeReg_a.
REQ-008 alloc_a  output  freeRegStruct  oldest free register offered to rename.
REQ-009 alloc_b  output  freeRegStruct  second-oldest free register offered to rename.
REQ-010 alloc_ack_a  input  1  rename consumes alloc_a this cycle.
REQ-011 alloc_ack_b  input  1  rename consumes alloc_b this cycle.
REQ-012 free_count  output  $clog2(CAP+1)  entries currently held.
REQ-013 overflow_err  output  1  sticky flag: a push was dropped.
REQ-014 underflow_err  output  1  sticky flag: an illegal or unbacked ack was seen.

Function
REQ-015 The block SHALL be a circular FIFO of CAP entries, PREG_W wide, with head pointer, tail pointer and count registers; both pointers wrap modulo CAP.
REQ-016 alloc_a SHALL drive valid=(count>=1) and reg_addr=mem[head] combinationally from registered state only, with no path from ack or freeReg inputs.
REQ-017 alloc_b SHALL drive valid=(count>=2) and reg_addr=mem[(head+1) mod CAP]; when valid is 0, reg_addr SHALL be 0.
REQ-018 The pop count SHALL be 0, 1 or 2:
- 1 when only ack_a is asserted and alloc_a.valid is 1.
- 2 when ack_a and ack_b are both asserted and alloc_b.valid is 1.
- Otherwise the block SHALL pop nothing.
REQ-019 Any of the following SHALL pop nothing and set underflow_err:
- ack_b asserted without ack_a.
- ack_a asserted while alloc_a.valid is 0.
- ack_b asserted while alloc_b.valid is 0.
REQ-020 A release SHALL count as a push only when valid=1 and reg_addr is not 0; a release of register 0 SHALL be silently dropped.
REQ-021 Pushes SHALL be written in order: a first, at tail; then b, at tail+1 if a pushed, or at tail otherwise.
REQ-022 Pushes and pops in the same cycle SHALL both take effect. The capacity check SHALL use count-pops+pushes<=CAP, so a push into a full list is accepted when a pop happens in the same cycle.
REQ-023 If the capacity check fails, the block SHALL drop push b first, then push a, and set overflow_err for each drop.
REQ-024 A register pushed in cycle N SHALL first be offered on alloc_a or alloc_b in cycle N+1; there is no same-cycle bypass.
REQ-025 The next count SHALL equal count-pops+accepted pushes and SHALL never exceed CAP or fall below 0.
REQ-026 free_count SHALL equal the registered count.
REQ-027 overflow_err and underflow_err SHALL clear only on reset.

Reset
REQ-028 While rst_n is 0, the block SHALL hold: head=0, tail=0, count=CAP, mem[i]=NUM_AREGS+i for i in 0..CAP-1.
REQ-029 While rst_n is 0, the outputs SHALL be: alloc_a={1,32}, alloc_b={1,33}, free_count=32, both error flags 0.
REQ-030 A reset asserted mid-operation SHALL discard all pending pushes and pops immediately, without waiting for a clock edge.
REQ-031 The first posedge after rst_n deasserts SHALL process inputs normally.

Structure
REQ-032 NUM_PREGS, NUM_AREGS and PREG_W SHALL be defined in the typedefs package. freeRegStruct is reused unchanged.
REQ-033 The block SHALL contain no sub-module; storage is an internal register array.
REQ-034 The block SHALL include concurrent assertions for:
- count<=CAP.
- No acks during reset.
- No two pushes of the same reg_addr in one cycle.

Verification
REQ-035 Reset, then idle -> alloc_a={1,32}, alloc_b={1,33}, free_count=32.
REQ-036 Set ack_a and ack_b for 16 cycles -> registers 32..63 are handed out in order; then free_count=0, both alloc valids are 0, and no error flags are set.
REQ-037 From empty, push freeReg_a=5 and freeReg_b=9 in one cycle -> next cycle alloc_a={1,5}, alloc_b={1,9}, free_count=2.
REQ-038 Full list: push a=40 and b=41 together with a single ack_a -> push a is accepted, push b is dropped, overflow_err=1, free_count=32.
REQ-039 Count=1: assert ack_a and ack_b -> nothing pops, underflow_err=1, free_count stays 1. Separately, freeReg_a={1,0} -> no push occurs.
REQ-040 Wrap-around: run pops and pushes past index 31, then pull rst_n low mid-cycle -> outputs return to the REQ-029 values asynchronously.
